// File: rtl/rx_fifo_if.sv
// Receive-side bus of rx_fifo_ctrl: receiver handshake in, FIFO read port and status out.
interface rx_fifo_if #(
  parameter int DEPTH = 4
);
  logic                       rx_req;
  logic                       rx_ack;
  logic [7:0]                 rx_data;
  logic                       rx_perr;
  logic                       rd_en;
  logic [7:0]                 dout;
  logic                       dout_perr;
  logic                       empty;
  logic                       full;
  logic [$clog2(DEPTH):0]     count;
  logic [7:0]                 perr_cnt;
  logic [7:0]                 ovf_cnt;

  modport slave (
    input  rx_req, rx_data, rx_perr, rd_en,
    output rx_ack, dout, dout_perr, empty, full, count, perr_cnt, ovf_cnt
  );

  modport master (
    output rx_req, rx_data, rx_perr, rd_en,
    input  rx_ack, dout, dout_perr, empty, full, count, perr_cnt, ovf_cnt
  );
endinterface

// File: rtl/rx_fifo_ctrl.sv
// Owns the UART receiver's Receive/Received handshake and buffers each byte plus
// parity flag in a first-word-fall-through FIFO with saturating error counters.
module rx_fifo_ctrl #(
  parameter int DEPTH     = 4,
  parameter bit DROP_PERR = 1'b1
) (
  input logic     clk,
  input logic     reset,
  rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [7:0]      perr_q, ovf_q;
  logic [8:0]      mem [DEPTH];

  logic capture, drop_perr, do_wr, do_rd, do_ovf, full_w, empty_w;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.rx_req)  state_nx = ACK;
      ACK:     if (!bus.rx_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == CW'(DEPTH));
  assign capture   = (state == IDLE) && bus.rx_req;
  assign drop_perr = DROP_PERR && bus.rx_perr;
  assign do_rd     = bus.rd_en && !empty_w;
  // A pop on the same edge frees the slot a full FIFO needs for the incoming byte.
  assign do_wr     = capture && !drop_perr && (!full_w || do_rd);
  assign do_ovf    = capture && !drop_perr && full_w && !do_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      perr_q  <= '0;
      ovf_q   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (capture && bus.rx_perr && perr_q != 8'hFF) perr_q <= perr_q + 8'd1;
      if (do_ovf && ovf_q != 8'hFF)                  ovf_q  <= ovf_q + 8'd1;
    end
  end

  // NOTE: the storage array is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {bus.rx_perr, bus.rx_data};
  end

  // Gating on empty keeps dout at zero out of reset without clearing the array.
  assign {bus.dout_perr, bus.dout} = empty_w ? 9'd0 : mem[rd_ptr];
  assign bus.rx_ack   = (state == ACK);
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.perr_cnt = perr_q;
  assign bus.ovf_cnt  = ovf_q;
endmodule

// File: doc/rx_fifo_ctrl.md
# rx_fifo_ctrl

Receive-side controller that sits between the UART receiver and downstream consumers such as display or command logic. It owns the receiver's four-phase Receive/Received handshake and captures each received byte with its parity flag into a small first-word-fall-through FIFO. It also keeps saturating counts of parity errors and overflow drops. Consumers read bytes at their own pace instead of holding the receiver.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- DROP_PERR, 1, 1 = discard bytes with parity error; 0 = store them with the flag set
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- rx_req  input  1  receiver's Receive strobe (byte valid)
- rx_ack  output  1  drives receiver's Received input
- rx_data  input  8  receiver Dout
- rx_perr  input  1  receiver parityErr
- rd_en  input  1  consumer pop request
- dout  output  8  head-of-FIFO byte
- dout_perr  output  1  parity flag of head entry
- empty  output  1  FIFO holds no entries
- full  output  1  FIFO holds DEPTH entries
- count  output  $clog2(DEPTH)+1  current occupancy
- perr_cnt  output  8  parity errors seen, saturating
- ovf_cnt  output  8  bytes dropped because FIFO full, saturating

## Operation
- Handshake FSM, two states:
  - IDLE: rx_ack=0. On a clock edge with rx_req=1, capture the byte and go to ACK.
  - ACK: rx_ack=1. Stay in ACK while rx_req=1. On rx_req=0, go to IDLE.
- rx_ack is a registered output equal to (state==ACK).
- Exactly one capture occurs per rx_req assertion, however long rx_req is held.
- Capture decision, evaluated on the IDLE→ACK edge:
  - rx_perr=1: perr_cnt increments.
  - rx_perr=1 and DROP_PERR=1: the byte is discarded and no write occurs.
  - Otherwise, if the FIFO is not full, or rd_en pops in the same cycle: write {rx_perr, rx_data} at the tail.
  - Otherwise: discard the byte and increment ovf_cnt.
- A dropped byte is still acknowledged. The receiver is never stalled.
- Read: rd_en=1 with empty=0 advances the head. rd_en while empty is ignored, and no state changes.
- Simultaneous write and read:
  - count is unchanged.
  - When full, the write is accepted because the pop frees a slot.
  - When empty, the written byte appears on dout after the edge. It is not bypassed into the same-cycle read.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally at DEPTH.
- count is incremented or decremented, never recomputed from pointers.
- full = (count==DEPTH); empty = (count==0).
- perr_cnt and ovf_cnt hold at 255.
- dout/dout_perr show the head entry whenever empty=0. When empty=1, their values are don't-care.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, rx_ack=0, pointers=0, count=0, empty=1, full=0.
  - perr_cnt=0, ovf_cnt=0, dout=0, dout_perr=0.
- Capture latency: rx_req sampled high at edge N. At N+1, rx_ack=1, count has incremented, and the byte is visible on dout if the FIFO was empty.
- Release: rx_req sampled low at edge M makes rx_ack=0 after M. A new request can be captured at M+1 at the earliest.
- Pop latency: rd_en sampled at edge N presents the next entry on dout after N.
- Reset mid-handshake: FSM returns to IDLE and FIFO contents are lost. If rx_req is high at the first edge after reset deasserts, it is treated as a new request.
- No combinational path from rx_req or rd_en to any output.

## Test plan
- Send 0x41, 0x42, 0x43 with rx_perr=0 and no reads → count=3, dout=0x41. Then 3 pops → dout sequence 0x41, 0x42, 0x43, empty=1.
- rx_req held high 10 cycles with rx_data=0x5A → exactly one entry, rx_ack high from cycle 1 until one cycle after rx_req falls.
- DEPTH=4: send 6 bytes 0x10–0x15 with no reads → full=1, ovf_cnt=2, pops return 0x10–0x13. All 6 requests are acknowledged.
- Parity error on 0x77:
  - DROP_PERR=1 → perr_cnt=1, count unchanged.
  - DROP_PERR=0 → entry stored, dout=0x77 and dout_perr=1 at head.
- FIFO full, rd_en=1 on the same edge as a new capture of 0x99 → count stays 4, 0x99 is the last entry popped, ovf_cnt unchanged.
- Assert reset while in ACK with 2 entries stored → rx_ack=0, empty=1, counts=0 immediately.
- Drive perr_cnt past 255 → it holds at 255.
